// File: rtl/memory_dump_printer.sv
// memory_dump_printer: snapshots a multi-channel memory bus and streams one
// framed word per qualifying slot to the UART writer (full or delta mode).
module memory_dump_printer #(
    parameter int                     UART_BUS_SIZE = 8,
    parameter int                     SLOT_SIZE     = 8,
    parameter int                     SLOTS         = 4,
    parameter int                     CHANNELS      = 2,
    parameter logic [UART_BUS_SIZE-1:0] INFO_PREFIX = 8'hFF
) (
    input  logic                                  i_clk,
    input  logic                                  i_reset,
    input  logic                                  i_start,
    input  logic                                  i_delta_mode,
    input  logic [CHANNELS-1:0]                   i_channel_mask,
    input  logic                                  i_abort,
    input  logic [CHANNELS*SLOTS*SLOT_SIZE-1:0]   i_memory_content,
    input  logic [UART_BUS_SIZE-1:0]              i_clk_cycle,
    input  logic                                  i_wr_end,
    output logic                                  o_start_wr,
    output logic [3*UART_BUS_SIZE+SLOT_SIZE-1:0]  o_data_wr,
    output logic                                  o_busy,
    output logic                                  o_end
);

    localparam int NSLOT = CHANNELS * SLOTS;
    localparam int PW    = $clog2(NSLOT + 1);
    localparam int MW    = NSLOT * SLOT_SIZE;

    typedef enum logic [1:0] {IDLE, SCAN, SEND, WAIT_WR} state_t;

    state_t                   state, state_n;
    logic [PW-1:0]            ptr;
    logic [MW-1:0]            snap_r;
    logic [MW-1:0]            shadow_r;
    logic [UART_BUS_SIZE-1:0] cyc_r;
    logic                     delta_r;
    logic [CHANNELS-1:0]      mask_r;
    logic [NSLOT-1:0]         slot_q;
    logic [SLOT_SIZE-1:0]     cur_slot;
    logic                     cur_qual;
    logic                     capture, load_frame, ptr_inc;
    logic                     start_wr_n, end_n;
    logic                     past_last;

    // Per-slot qualification: channel enabled and either full mode or changed since last print
    for (genvar g = 0; g < NSLOT; g++) begin : g_qual
        assign slot_q[g] = mask_r[g / SLOTS] &&
                           (!delta_r || (snap_r[g*SLOT_SIZE +: SLOT_SIZE] != shadow_r[g*SLOT_SIZE +: SLOT_SIZE]));
    end

    assign past_last = (ptr >= PW'(NSLOT));

    // Select the snapshot slot and qualification bit under the pointer
    always_comb begin
        cur_slot = '0;
        cur_qual = 1'b0;
        for (int i = 0; i < NSLOT; i++) begin
            if (ptr == PW'(i)) begin
                cur_slot = snap_r[i*SLOT_SIZE +: SLOT_SIZE];
                cur_qual = slot_q[i];
            end
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state <= IDLE;
        else          state <= state_n;
    end

    // Next-state logic; abort wins over everything outside IDLE
    always_comb begin
        state_n    = state;
        capture    = 1'b0;
        load_frame = 1'b0;
        ptr_inc    = 1'b0;
        start_wr_n = 1'b0;
        end_n      = o_end;
        case (state)
            IDLE: begin
                if (i_start) begin
                    capture = 1'b1;
                    end_n   = 1'b0;
                    state_n = SCAN;
                end
            end
            SCAN: begin
                if (i_abort || past_last) begin
                    end_n   = 1'b1;
                    state_n = IDLE;
                end else if (cur_qual) begin
                    load_frame = 1'b1;
                    ptr_inc    = 1'b1;
                    start_wr_n = 1'b1;
                    state_n    = SEND;
                end else begin
                    ptr_inc = 1'b1;
                end
            end
            SEND: begin
                if (i_abort) begin
                    end_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    state_n = WAIT_WR;
                end
            end
            WAIT_WR: begin
                if (i_abort) begin
                    end_n   = 1'b1;
                    state_n = IDLE;
                end else if (i_wr_end) begin
                    if (past_last) begin
                        end_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = SCAN;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Snapshot, mode/mask latch, pointer, shadow and registered outputs
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ptr        <= '0;
            snap_r     <= '0;
            shadow_r   <= '0;
            cyc_r      <= '0;
            delta_r    <= 1'b0;
            mask_r     <= '0;
            o_start_wr <= 1'b0;
            o_data_wr  <= '0;
            o_busy     <= 1'b0;
            o_end      <= 1'b0;
        end else begin
            if (capture) begin
                snap_r  <= i_memory_content;
                cyc_r   <= i_clk_cycle;
                delta_r <= i_delta_mode;
                mask_r  <= i_channel_mask;
                ptr     <= '0;
            end else if (ptr_inc) begin
                ptr <= ptr + 1'b1;
            end
            if (load_frame) begin
                o_data_wr <= {INFO_PREFIX, cyc_r, UART_BUS_SIZE'(ptr), cur_slot};
                for (int i = 0; i < NSLOT; i++) begin
                    if (ptr == PW'(i))
                        shadow_r[i*SLOT_SIZE +: SLOT_SIZE] <= snap_r[i*SLOT_SIZE +: SLOT_SIZE];
                end
            end
            o_start_wr <= start_wr_n;
            o_busy     <= (state_n != IDLE);
            o_end      <= end_n;
        end
    end

endmodule

// File: tb/tb_memory_dump_printer.sv
// Directed bench for memory_dump_printer with a frame scoreboard and a
// reference shadow model.
module tb_memory_dump_printer;

    localparam int U  = 8;
    localparam int S  = 8;
    localparam int SL = 4;
    localparam int CH = 2;
    localparam int N  = CH * SL;
    localparam int FW = 3 * U + S;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b0;
    logic          i_start = 1'b0;
    logic          i_delta_mode = 1'b0;
    logic [CH-1:0] i_channel_mask = '0;
    logic          i_abort = 1'b0;
    logic [N*S-1:0] i_memory_content = '0;
    logic [U-1:0]  i_clk_cycle = '0;
    logic          i_wr_end = 1'b0;
    logic          o_start_wr;
    logic [FW-1:0] o_data_wr;
    logic          o_busy;
    logic          o_end;

    memory_dump_printer #(
        .UART_BUS_SIZE(U), .SLOT_SIZE(S), .SLOTS(SL), .CHANNELS(CH), .INFO_PREFIX(8'hFF)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_delta_mode(i_delta_mode),
        .i_channel_mask(i_channel_mask), .i_abort(i_abort), .i_memory_content(i_memory_content),
        .i_clk_cycle(i_clk_cycle), .i_wr_end(i_wr_end), .o_start_wr(o_start_wr),
        .o_data_wr(o_data_wr), .o_busy(o_busy), .o_end(o_end)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [FW-1:0] frame;
        int            slot;
    } exp_t;

    exp_t       sb[$];
    logic [S-1:0] mem [N];
    logic [S-1:0] msh [N];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [N*S-1:0] pack_mem();
        logic [N*S-1:0] v;
        for (int i = 0; i < N; i++) v[i*S +: S] = mem[i];
        return v;
    endfunction

    // One dump: model pushes expected frames, bench plays the UART writer.
    task automatic run_dump(input string name, input logic delta, input logic [CH-1:0] mask,
                            input logic [U-1:0] cy, input int abort_after, input int exp_end_cyc);
        int   nq, cyc, prev_slot, last_w, pulses, expc;
        exp_t e;
        sb.delete();
        nq = 0;
        for (int p = 0; p < N; p++) begin
            if (mask[p / SL] && (!delta || mem[p] != msh[p]) && (abort_after == 0 || nq < abort_after)) begin
                e.frame = {8'hFF, cy, 8'(p), mem[p]};
                e.slot  = p;
                sb.push_back(e);
                msh[p] = mem[p];
                nq++;
            end
        end
        i_memory_content = pack_mem();
        i_clk_cycle      = cy;
        i_delta_mode     = delta;
        i_channel_mask   = mask;
        i_start          = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        cyc = 1;
        chk({name, "_busy_rise"}, 32'(o_busy), 32'd1);
        chk({name, "_end_cleared"}, 32'(o_end), 32'd0);
        prev_slot = -1;
        last_w    = -1;
        pulses    = 0;
        while (!o_end && cyc < 300) begin
            if (o_start_wr) begin
                pulses++;
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk({name, "_frame"}, o_data_wr, e.frame);
                    expc = (last_w < 0) ? 2 + e.slot : last_w + 2 + (e.slot - prev_slot - 1);
                    chk({name, "_pulse_cycle"}, 32'(cyc), 32'(expc));
                    prev_slot = e.slot;
                end else begin
                    chk({name, "_extra_pulse"}, 32'(pulses), 32'(nq));
                end
                @(negedge i_clk);
                cyc++;
                chk({name, "_pulse_width"}, 32'(o_start_wr), 32'd0);
                i_memory_content = ~pack_mem();
                i_clk_cycle      = ~cy;
                if (pulses == abort_after) begin
                    i_abort = 1'b1;
                    @(negedge i_clk);
                    cyc++;
                    i_abort = 1'b0;
                    chk({name, "_abort_end"}, 32'(o_end), 32'd1);
                    chk({name, "_abort_idle"}, 32'(o_busy), 32'd0);
                    chk({name, "_abort_nopulse"}, 32'(o_start_wr), 32'd0);
                end else begin
                    i_wr_end = 1'b1;
                    i_start  = 1'b1;
                    last_w   = cyc;
                    @(negedge i_clk);
                    cyc++;
                    i_wr_end = 1'b0;
                    i_start  = 1'b0;
                end
                i_memory_content = pack_mem();
                i_clk_cycle      = cy;
            end else begin
                @(negedge i_clk);
                cyc++;
            end
        end
        chk({name, "_done"}, 32'(o_end), 32'd1);
        chk({name, "_busy_fall"}, 32'(o_busy), 32'd0);
        chk({name, "_missing_frames"}, 32'(sb.size()), 32'd0);
        chk({name, "_pulse_count"}, 32'(pulses), 32'(nq));
        if (exp_end_cyc > 0) chk({name, "_end_latency"}, 32'(cyc), 32'(exp_end_cyc));
        @(negedge i_clk);
        chk({name, "_start_ignored"}, 32'(o_busy), 32'd0);
        chk({name, "_end_held"}, 32'(o_end), 32'd1);
    endtask

    initial begin
        int t;
        for (int i = 0; i < N; i++) begin mem[i] = '0; msh[i] = '0; end

        // Reset state
        @(negedge i_clk);
        @(negedge i_clk);
        chk("rst_start_wr", 32'(o_start_wr), 32'd0);
        chk("rst_data_wr", o_data_wr, 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_end", 32'(o_end), 32'd0);
        i_reset = 1'b1;
        @(negedge i_clk);

        // Full dump of 0x10..0x17
        for (int i = 0; i < N; i++) mem[i] = 8'h10 + 8'(i);
        run_dump("full11", 1'b0, 2'b11, 8'h2A, 0, 0);

        // Delta: only slot 5 changed
        mem[5] = 8'hAB;
        run_dump("delta_one", 1'b1, 2'b11, 8'h33, 0, 0);

        // Full dump, channel 1 only, new content; then delta shows channel 0 shadow untouched
        for (int i = 0; i < N; i++) mem[i] = 8'h20 + 8'(i);
        run_dump("full10", 1'b0, 2'b10, 8'h40, 0, 0);
        run_dump("delta_ch0", 1'b1, 2'b11, 8'h41, 0, 0);

        // Delta with no changes: no pulses, end at N+10
        run_dump("delta_none", 1'b1, 2'b11, 8'h50, 0, 10);

        // Full with mask 0: nothing qualifies
        run_dump("mask0", 1'b0, 2'b00, 8'h51, 0, 10);

        // Abort in WAIT_WR of 3rd frame, then delta prints the remainder
        for (int i = 0; i < N; i++) mem[i] = 8'h40 + 8'(i);
        run_dump("abort3", 1'b1, 2'b11, 8'h60, 3, 0);
        run_dump("after_abort", 1'b1, 2'b11, 8'h61, 0, 0);

        // Asynchronous reset pulsed mid-SEND
        for (int i = 0; i < N; i++) mem[i] = 8'h70 + 8'(i);
        i_memory_content = pack_mem();
        i_delta_mode     = 1'b0;
        i_channel_mask   = 2'b11;
        i_start          = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        t = 0;
        while (!o_start_wr && t < 50) begin @(negedge i_clk); t++; end
        chk("rst_mid_reach_send", 32'(o_start_wr), 32'd1);
        #2;
        i_reset = 1'b0;
        #1;
        chk("rst_mid_start_wr", 32'(o_start_wr), 32'd0);
        chk("rst_mid_data_wr", o_data_wr, 32'd0);
        chk("rst_mid_busy", 32'(o_busy), 32'd0);
        chk("rst_mid_end", 32'(o_end), 32'd0);
        @(negedge i_clk);
        i_reset = 1'b1;
        for (int i = 0; i < N; i++) msh[i] = '0;
        @(negedge i_clk);
        chk("post_rst_idle", 32'(o_busy), 32'd0);

        // First delta after reset prints every nonzero enabled slot
        mem[2] = 8'h00;
        run_dump("delta_post_rst", 1'b1, 2'b11, 8'h77, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_dump_printer.md
# memory_dump_printer

Multi-channel, parametrised memory dump printer for the debugger. On a start request it snapshots a flat multi-channel memory bus and the current clock-cycle count. It then emits one framed word per slot to the UART writer, using a start/end handshake. Two modes are supported: a full dump, and a delta dump that prints only slots changed since their last print. Per-channel enable masking and an abort input are also provided. It sits between the datapath memory taps and the debugger's UART transmit sequencer.

## Interface

- UART_BUS_SIZE, 8, width of the prefix, cycle and address fields of a frame
- SLOT_SIZE, 8, width of one memory slot (frame payload)
- SLOTS, 4, slots per channel; CHANNELS*SLOTS must be <= 2^UART_BUS_SIZE
- CHANNELS, 2, number of memory channels
- INFO_PREFIX, 8'hFF, constant frame prefix (UART_BUS_SIZE bits)
- i_clk  in  1  clock, all logic on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_start  in  1  dump request, sampled in IDLE only
- i_delta_mode  in  1  0 = full dump, 1 = changed-only; sampled with i_start
- i_channel_mask  in  CHANNELS  bit c = 1 enables channel c; sampled with i_start
- i_abort  in  1  terminate the dump in progress
- i_memory_content  in  CHANNELS*SLOTS*SLOT_SIZE  flat bus; slot s of channel c at bits [(c*SLOTS+s)*SLOT_SIZE +: SLOT_SIZE]
- i_clk_cycle  in  UART_BUS_SIZE  current cycle count
- i_wr_end  in  1  UART writer finished the current frame
- o_start_wr  out  1  one-cycle write request
- o_data_wr  out  3*UART_BUS_SIZE+SLOT_SIZE  frame {INFO_PREFIX, cycle, address, slot}
- o_busy  out  1  high in any state other than IDLE
- o_end  out  1  dump complete; held until next accepted start

## Operation

- States: IDLE, SCAN, SEND, WAIT_WR.
- IDLE, i_start=1:
  - Latch i_memory_content into the snapshot register and i_clk_cycle into the cycle register.
  - Latch the mode and mask.
  - Clear the pointer and o_end, then go to SCAN.
- SCAN examines one slot per cycle at flat pointer p = c*SLOTS+s. The slot qualifies if mask[c]=1 and either full mode is set or snapshot[p] != shadow[p].
  - Qualifies: load o_data_wr with {INFO_PREFIX, latched cycle, p zero-extended to UART_BUS_SIZE, snapshot[p]}, write shadow[p] <= snapshot[p], increment p, go to SEND.
  - Does not qualify: increment p and stay in SCAN.
  - After slot CHANNELS*SLOTS-1 has been handled with no pending frame: set o_end=1 and go to IDLE.
- SEND: o_start_wr=1 for this cycle only, then go to WAIT_WR.
- WAIT_WR: wait for i_wr_end=1, then go to SCAN, or to IDLE with o_end=1 if p has passed the last slot.
- i_wr_end is ignored outside WAIT_WR.
- Shadow register (CHANNELS*SLOTS*SLOT_SIZE): reset to 0 and updated only for printed slots. Disabled channels keep their shadow values. The first delta dump after reset therefore prints every nonzero enabled slot.
- Full mode also updates the shadow for every printed slot.
- i_abort=1 in SCAN, SEND or WAIT_WR: go to IDLE next cycle with o_end=1 and o_start_wr=0. Shadow updates already made are kept. i_abort has priority over i_wr_end.
- i_abort in IDLE has no effect. i_start outside IDLE is ignored.
- i_memory_content changes during a dump do not affect the dump (snapshot).

## Timing

- Reset values: state IDLE, o_start_wr 0, o_end 0, o_busy 0, o_data_wr 0, pointer 0, shadow 0. Reset takes effect immediately and asynchronously, in any state, mid-frame included.
- All outputs are registered.
- Start sampled at edge N: o_busy=1 from N+1.
- First qualifying slot at pointer k (k skipped slots before it): o_start_wr high in cycle N+2+k, with o_data_wr valid the same cycle and stable until the next frame load.
- Each subsequent frame: SEND pulse 2 cycles after the i_wr_end edge if the next slot qualifies, plus 1 cycle per skipped slot.
- Nothing qualifies (mask=0 or delta with no changes): o_end=1 and o_busy=0 at N+1+CHANNELS*SLOTS+1 (e.g. N+10 for the defaults).
- i_wr_end and i_start together in the final WAIT_WR cycle: the start is ignored (state is not IDLE).

## Test plan

- Defaults, full mode, mask 2'b11, content slots 0x10..0x17, cycle 0x2A -> 8 pulses. Frames FF_2A_00_10 … FF_2A_07_17 in order. o_end after the 8th i_wr_end.
- Same content, then delta dump with only slot 5 changed to 0xAB -> exactly one frame FF_cc_05_AB. Then o_end.
- Full mode, mask 2'b10 -> frames for addresses 04..07 only. Channel-0 shadow unchanged, verified by a subsequent delta dump.
- Delta dump with no changes, mask 2'b11 -> no o_start_wr. o_end rises 10 cycles after the start edge.
- i_abort asserted during WAIT_WR of the 3rd frame -> IDLE next cycle, o_end=1, no further pulses. A following delta dump prints only the unprinted slots.
- Async reset pulsed low mid-SEND -> all outputs 0 immediately. i_start while busy ignored; o_data_wr unchanged by input changes mid-dump.
